// File: rtl/bht_update_queue.sv
// Branch-resolution queue feeding BHT updates from execute back to the predictor,
// with saturating branch / mispredict statistics counters.
module bht_update_queue #(
  parameter int INDEX_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_res_valid,
  input  logic                   i_res_taken,
  input  logic                   i_res_pred_taken,
  input  logic [INDEX_WIDTH-1:0] i_res_index,
  output logic                   o_res_ready,
  input  logic                   i_stall_fetch,
  output logic                   o_bht_update,
  output logic                   o_branch_taken,
  output logic [INDEX_WIDTH-1:0] o_set_index_exec,
  output logic                   o_mispredict,
  input  logic                   i_stats_clear,
  output logic [CNT_W-1:0]       o_branch_count,
  output logic [CNT_W-1:0]       o_mispred_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic                   taken;
    logic [INDEX_WIDTH-1:0] index;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             accept, pop, is_mispred;
  entry_t           head;

  // Wrap bit distinguishes full from empty when the low pointer bits match.
  assign o_empty     = (wr_ptr_q == rd_ptr_q);
  assign o_full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign o_res_ready = ~o_full;

  assign accept     = i_res_valid & o_res_ready;
  assign o_bht_update = ~o_empty;
  assign pop        = o_bht_update & ~i_stall_fetch;
  assign is_mispred = i_res_taken ^ i_res_pred_taken;

  assign head             = mem_q[rd_ptr_q[AW-1:0]];
  assign o_branch_taken   = head.taken;
  assign o_set_index_exec = head.index;

  assign o_mispredict    = mispredict_q;
  assign o_branch_count  = branch_cnt_q;
  assign o_mispred_count = mispred_cnt_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mispredict_d  = accept & is_mispred;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (i_stats_clear) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (accept) begin
      if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + CNT_ONE;
      if (is_mispred && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mispredict_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mispredict_q  <= mispredict_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // NOTE: entry storage is not reset; equal pointers already mark every slot as invalid.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{taken: i_res_taken, index: i_res_index};
    end
  end

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 Parameter INDEX_WIDTH, default 5, sets the BHT set-index width and matches the predictor's index.
REQ-002 Parameter DEPTH, default 4, sets the queue entry count; it SHALL be a power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, sets the width of each statistics counter.
REQ-004 Port i_clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 Port i_arst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port i_res_valid, input, 1: the execute stage presents a resolved conditional branch.
REQ-007 Port i_res_taken, input, 1: actual branch outcome, 1 = taken.
REQ-008 Port i_res_pred_taken, input, 1: the prediction that fetch used for this branch.
REQ-009 Port i_res_index, input, INDEX_WIDTH: BHT set index of the resolved branch.
REQ-010 Port o_res_ready, output, 1: the queue can accept a result this cycle.
REQ-011 Port i_stall_fetch, input, 1: the predictor will not consume an update this cycle.
REQ-012 Port o_bht_update, output, 1: the head entry is presented to the predictor update port.
REQ-013 Port o_branch_taken, output, 1: outcome of the head entry.
REQ-014 Port o_set_index_exec, output, INDEX_WIDTH: set index of the head entry.
REQ-015 Port o_mispredict, output, 1: one-cycle pulse marking an accepted mispredicted branch.
REQ-016 Port i_stats_clear, input, 1: synchronous clear of both statistics counters.
REQ-017 Port o_branch_count, output, CNT_W: number of accepted branches.
REQ-018 Port o_mispred_count, output, CNT_W: number of accepted mispredicted branches.
REQ-019 Ports o_full and o_empty, outputs, 1 each: queue occupancy status.

Function
REQ-020 The queue SHALL be a circular FIFO with read and write pointers of log2(DEPTH)+1 bits; the top bit is the wrap bit.
REQ-021 o_empty = pointers equal; o_full = low bits equal and wrap bits different; o_res_ready = ~o_full.
REQ-022 Accept = i_res_valid & o_res_ready; on accept, {taken, index} SHALL be written at the write pointer and the write pointer incremented.
REQ-023 i_res_valid while o_full SHALL be ignored (no write, no count); the producer holds or drops the result, which is its own concern.
REQ-024 o_bht_update = ~o_empty; o_branch_taken and o_set_index_exec SHALL show the head entry directly from storage, with no extra register stage.
REQ-025 Pop = o_bht_update & ~i_stall_fetch, matching the predictor's update gating; on pop the read pointer SHALL increment.
REQ-026 An entry accepted in cycle N SHALL first appear on o_bht_update in cycle N+1; there is no empty-queue bypass.
REQ-027 Simultaneous accept and pop SHALL both take effect and leave occupancy unchanged.
REQ-028 A pop while full frees a slot in the next cycle only; o_res_ready stays 0 in that same cycle.
REQ-029 Pointers SHALL wrap modulo 2*DEPTH, and entry order SHALL be strict FIFO across wrap-around.
REQ-030 o_mispredict SHALL be a registered pulse, high in cycle N+1 exactly when the cycle-N accept had i_res_taken != i_res_pred_taken.
REQ-031 On each accept, o_branch_count +1; on each mispredicted accept, o_mispred_count +1 as well.
REQ-032 Both counters SHALL saturate at all-ones and never wrap.
REQ-033 i_stats_clear SHALL zero both counters in the next cycle and takes priority over a same-cycle increment.
REQ-034 i_stats_clear SHALL NOT affect queue contents, pointers or o_mispredict.

Reset
REQ-035 While i_arst_n = 0, pointers = 0, o_empty = 1, o_full = 0, o_res_ready = 1, o_bht_update = 0, o_mispredict = 0 and both counters = 0.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries immediately and asynchronously; entry storage needs no reset.
REQ-037 After reset deasserts, the first accept SHALL be possible on the first rising clock edge.

Verification
REQ-038 Single push, i_stall_fetch = 0: accept {taken=1, index=5} in cycle 0 -> cycle 1 shows o_bht_update=1, o_set_index_exec=5, o_branch_taken=1; cycle 2 shows o_empty=1.
REQ-039 Fill with i_stall_fetch = 1: accept indices 1,2,3,4 -> o_full=1, o_res_ready=0; a fifth valid is ignored and o_branch_count=4; releasing the stall drains 1,2,3,4 in order over 4 cycles.
REQ-040 Wrap-around: stream 10 entries with pushes and pops interleaved under random stalls -> output order equals input order, with no loss or duplication.
REQ-041 Mispredict: accept {taken=0, pred=1} -> o_mispredict=1 for exactly one cycle and o_mispred_count=1; accept {taken=1, pred=1} -> no pulse.
REQ-042 Saturation and clear: with CNT_W=2, 5 accepts -> o_branch_count=3; i_stats_clear asserted together with an accept -> count 0 next cycle.
REQ-043 Reset with 3 entries queued: assert i_arst_n=0 asynchronously -> o_empty=1 and o_bht_update=0 with no clock edge, and counters read 0.
